// File: rtl/cacheline_burst_adapter.sv
// Converts 256-bit cache line requests into 4-beat 64-bit memory bursts.
// Define BURST_WRAP_EN for critical-beat-first (wrapping) beat ordering.
//
// state | meaning
// IDLE  | waiting for a cache read/write request
// READ  | collecting four read beats into the fill buffer
// WRITE | presenting four write beats from the latched line
// DONE  | one-cycle line-complete pulse on resp_o
module cacheline_burst_adapter (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [255:0]  wline_q, wline_d;
    logic [255:0]  rbuf_q, rbuf_d;
    logic [255:0]  line_q, line_d;
    logic [1:0]    slot;

`ifdef BURST_WRAP_EN
    logic unused_addr;
    assign slot        = addr_q[4:3] + cnt_q;
    assign address_o   = {addr_q[31:3], 3'b000};
    assign unused_addr = ^addr_q[2:0];
`else
    logic unused_addr;
    assign slot        = cnt_q;
    assign address_o   = {addr_q[31:5], 5'b00000};
    assign unused_addr = ^addr_q[4:0];
`endif

    assign burst_o = wline_q[{slot, 6'b000000} +: 64];
    assign line_o  = line_q;
    assign resp_o  = (state_q == DONE);
    assign read_o  = (state_q == READ);
    assign write_o = (state_q == WRITE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rbuf_d  = rbuf_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (write_i) begin
                    addr_d  = address_i;
                    wline_d = line_i;
                    cnt_d   = 2'd0;
                    state_d = WRITE;
                end else if (read_i) begin
                    addr_d  = address_i;
                    cnt_d   = 2'd0;
                    state_d = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    rbuf_d[{slot, 6'b000000} +: 64] = burst_i;
                    cnt_d = cnt_q + 2'd1;
                    // line_o only changes once the whole line has arrived
                    if (cnt_q == 2'd3) begin
                        line_d  = rbuf_d;
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 32'd0;
            wline_q <= 256'd0;
            rbuf_q  <= 256'd0;
            line_q  <= 256'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rbuf_q  <= rbuf_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Randomized bench for cacheline_burst_adapter against a line/beat-level model.
// Honours BURST_WRAP_EN in the model when the macro is defined for the build.
module tb_cacheline_burst_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int           total = 0;
    int           bad   = 0;
    logic [255:0] last_line = '0;

    cacheline_burst_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int slot_of(input logic [31:0] a, input int k);
`ifdef BURST_WRAP_EN
        return (int'(a[4:3]) + k) % 4;
`else
        return k % 4;
`endif
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef BURST_WRAP_EN
        return {a[31:3], 3'b000};
`else
        return {a[31:5], 5'b00000};
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input bit directed);
        logic [255:0] exp_line;
        logic [63:0]  d;
        logic         ack;
        int           k;
        int           stalls;
        exp_line  = last_line;
        k         = 0;
        stalls    = 0;
        read_i    = 1'b1;
        write_i   = 1'b0;
        address_i = addr;
        resp_i    = 1'($urandom % 2);
        burst_i   = {$urandom, $urandom};
        tick();
        address_i = $urandom;
        while (k < 4) begin
            check("rd_read_o", read_o, 1);
            check("rd_write_o", write_o, 0);
            check("rd_resp_o", resp_o, 0);
            check("rd_line_hold", line_o, last_line);
            check("rd_address_o", address_o, exp_addr(addr));
            ack = directed ? 1'b1 : ((($urandom % 2) == 1) || (stalls >= 3));
            d   = directed ? 64'hA0 + 64'(k) : {$urandom, $urandom};
            resp_i  = ack;
            burst_i = d;
            if (ack) begin
                exp_line[slot_of(addr, k) * 64 +: 64] = d;
                k++;
                stalls = 0;
            end else begin
                stalls++;
            end
            tick();
        end
        check("rd_done_resp_o", resp_o, 1);
        check("rd_done_read_o", read_o, 0);
        check("rd_line_o", line_o, exp_line);
        check("rd_done_address_o", address_o, exp_addr(addr));
        last_line = exp_line;
        read_i = 1'b0;
        resp_i = 1'($urandom % 2);
        tick();
        check("rd_idle_resp_o", resp_o, 0);
        check("rd_idle_line_o", line_o, last_line);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input bit both, input bit use_pat, input logic [15:0] pat);
        logic ack;
        int   k;
        int   stalls;
        int   cyc;
        int   resp_seen;
        k         = 0;
        stalls    = 0;
        cyc       = 0;
        resp_seen = 0;
        write_i   = 1'b1;
        read_i    = both;
        address_i = addr;
        line_i    = line;
        resp_i    = 1'($urandom % 2);
        tick();
        line_i    = {8{$urandom}};
        address_i = $urandom;
        while (k < 4) begin
            check("wr_write_o", write_o, 1);
            check("wr_read_o", read_o, 0);
            check("wr_resp_o", resp_o, 0);
            check("wr_address_o", address_o, exp_addr(addr));
            check("wr_burst_o", burst_o, 256'(line[slot_of(addr, k) * 64 +: 64]));
            check("wr_line_hold", line_o, last_line);
            if (use_pat) ack = (cyc < 16) ? pat[cyc] : 1'b1;
            else         ack = (($urandom % 2) == 1) || (stalls >= 3);
            resp_i  = ack;
            burst_i = {$urandom, $urandom};
            if (ack) begin
                k++;
                stalls = 0;
            end else begin
                stalls++;
            end
            cyc++;
            tick();
        end
        check("wr_done_resp_o", resp_o, 1);
        check("wr_done_write_o", write_o, 0);
        write_i = 1'b0;
        read_i  = 1'b0;
        resp_i  = 1'($urandom % 2);
        tick();
        check("wr_idle_resp_o", resp_o, 0);
        check("wr_idle_write_o", write_o, 0);
    endtask

    task automatic do_reset_mid_read;
        read_i    = 1'b1;
        write_i   = 1'b0;
        address_i = $urandom;
        resp_i    = 1'b0;
        tick();
        resp_i  = 1'b1;
        burst_i = {$urandom, $urandom};
        tick();
        burst_i = {$urandom, $urandom};
        tick();
        burst_i = {$urandom, $urandom};
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        read_i = 1'b0;
        resp_i = 1'b0;
        last_line = '0;
        check("rst_read_o", read_o, 0);
        check("rst_resp_o", resp_o, 0);
        check("rst_line_o", line_o, 0);
        check("rst_address_o", address_o, 0);
        check("rst_burst_o", burst_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_after_resp_o", resp_o, 0);
            check("rst_after_read_o", read_o, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]  a;
        logic [255:0] l;
        rst       = 1'b1;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        tick();
        tick();
        check("reset_resp_o", resp_o, 0);
        check("reset_read_o", read_o, 0);
        check("reset_write_o", write_o, 0);
        check("reset_line_o", line_o, 0);
        check("reset_burst_o", burst_o, 0);
        check("reset_address_o", address_o, 0);
        rst = 1'b0;
        tick();

        do_read(32'h0000_2000, 1'b1);
        check("a_line_abs", line_o, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
        check("a_addr_low", 256'(address_o[4:0]), 0);

        l = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        do_write(32'h0000_3000, l, 1'b0, 1'b1, 16'b0000_0000_0011_0101);
        do_write($urandom, {8{$urandom}}, 1'b1, 1'b0, 16'h0);
        do_reset_mid_read();
        do_read(32'h0000_1048, 1'b0);
`ifdef BURST_WRAP_EN
        check("wrap_addr_abs", address_o, 32'h0000_1048);
`else
        check("nowrap_addr_abs", address_o, 32'h0000_1040);
`endif

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            l = {8{$urandom}};
            if (($urandom % 2) == 1) do_read(a, 1'b0);
            else                     do_write(a, l, 1'($urandom % 2), 1'b0, 16'h0);
            if (($urandom % 8) == 0) begin
                resp_i = 1'b1;
                tick();
                check("idle_resp_ignored", resp_o, 0);
                check("idle_line_o", line_o, last_line);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
